// File: rtl/info_pattern_gen_mc_pkg.sv
// info_pattern_gen_mc_pkg
//   Shared types and helpers for the INFO pattern generator.
//   mode_e       : pattern selector (RAMP / CONST / PRBS32 / STAMP)
//   state_e      : generator FSM states
//   PRBS_POLY    : Galois feedback taps for x^32+x^22+x^2+x+1 (bits 22,2,1,0)
//   lane_reorder : output lane position for logical lane k (lane order reversed)
//   prbs_step    : one Galois shift of the PRBS32 register
package info_pattern_gen_mc_pkg;

   localparam int          LANE_W    = 16;
   localparam logic [31:0] PRBS_POLY = 32'h0040_0007;

   typedef enum logic [1:0] {
      MODE_RAMP  = 2'd0,
      MODE_CONST = 2'd1,
      MODE_PRBS  = 2'd2,
      MODE_STAMP = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_GEN  = 2'd2,
      ST_NEXT = 2'd3
   } state_e;

   // The downstream packer expects lanes most-significant first.
   function automatic int unsigned lane_reorder(input int unsigned k, input int unsigned lanes);
      return lanes - 1 - k;
   endfunction

   function automatic logic [31:0] prbs_step(input logic [31:0] s);
      return s[31] ? ({s[30:0], 1'b0} ^ PRBS_POLY) : {s[30:0], 1'b0};
   endfunction

endpackage

// File: rtl/info_pattern_gen_mc_if.sv
// info_pattern_gen_mc_if
//   AXI-Stream style bus carrying the generated INFO records.
//   tdata/tvalid/tlast/tdest/tuser flow master -> slave, tready flows back.
interface info_pattern_gen_mc_if #(
   parameter int DATA_W = 512,
   parameter int CH_W   = 2
) ();
   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic [CH_W-1:0]   tdest;
   logic              tuser;

   modport master (output tdata, output tvalid, output tlast, output tdest, output tuser,
                   input tready);
   modport slave  (input tdata, input tvalid, input tlast, input tdest, input tuser,
                   output tready);
endinterface

// File: rtl/info_pattern_gen_mc_prbs32.sv
// info_pattern_gen_mc_prbs32
//   PRBS32 register. load reseeds (seed 0 becomes 1 so the register never locks up),
//   step advances one Galois shift. prbs_next is the value the register takes at the
//   next edge, so the parent can register beat data in the same cycle the state moves.
//   clk, rst_n : clock, async active-low reset
//   load, seed : reseed request and seed value
//   step       : advance once
//   prbs_next  : next-state value
module info_pattern_gen_mc_prbs32
   import info_pattern_gen_mc_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] seed,
   output logic [31:0] prbs_next
);
   logic [31:0] state_q, state_d;

   always_comb begin
      state_d = state_q;
      if (load)
         state_d = (seed == 32'h0) ? 32'h1 : seed;
      else if (step)
         state_d = prbs_step(state_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= 32'h0;
      else        state_q <= state_d;
   end

   assign prbs_next = state_d;
endmodule

// File: rtl/info_pattern_gen_mc.sv
// info_pattern_gen_mc
//   Trigger-driven multi-channel INFO pattern source. Every trigger queues one line;
//   a line emits one record of cfg_info_len beats per enabled channel (ascending),
//   split into cfg_burst_len-beat packets with tdest = channel.
//   clk, rst_n          : clock, async active-low reset
//   trigger, cfg_*      : line trigger and per-line configuration (latched on dequeue)
//   m_axis (master)     : pattern stream, all outputs registered
//   busy                : FSM not idle
//   line_cnt            : completed lines (wraps)
//   trig_drop_cnt       : lost triggers (saturating)
module info_pattern_gen_mc
   import info_pattern_gen_mc_pkg::*;
#(
   parameter int DATA_W  = 512,
   parameter int NUM_CH  = 4,
   parameter int LEN_W   = 16,
   parameter int TRIG_Q  = 8,
   parameter int REORDER = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                trigger,
   input  logic                cfg_en,
   input  logic [1:0]          cfg_mode,
   input  logic [NUM_CH-1:0]   cfg_ch_en,
   input  logic [LEN_W-1:0]    cfg_info_len,
   input  logic [LEN_W-1:0]    cfg_burst_len,
   input  logic [31:0]         cfg_seed,
   info_pattern_gen_mc_if.master m_axis,
   output logic                busy,
   output logic [31:0]         line_cnt,
   output logic [31:0]         trig_drop_cnt
);
   localparam int LANES  = DATA_W / LANE_W;
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PEND_W = $clog2(TRIG_Q + 1);

   state_e              state_q, state_d;
   logic [PEND_W-1:0]   pend_q, pend_d;
   mode_e               mode_q, mode_d;
   logic [NUM_CH-1:0]   mask_q, mask_d;
   logic [LEN_W-1:0]    len_q, len_d, blen_q, blen_d;
   logic [31:0]         seed_q, seed_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic [LEN_W-1:0]    beat_q, beat_d, burst_q, burst_d;
   logic [15:0]         base_q, base_d;
   logic [31:0]         line_q, line_d, drop_q, drop_d;
   logic                busy_q, busy_d;
   logic [DATA_W-1:0]   tdata_q, tdata_d, tdata_pat;
   logic                tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
   logic [CH_W-1:0]     tdest_q, tdest_d;

   logic                accept, deq, start_rec, load_data, line_inc;
   logic [1:0]          drop_inc;
   logic [CH_W-1:0]     rec_ch, first_ch, next_ch;
   logic                first_found, next_found;
   logic [32:0]         drop_sum;
   logic [31:0]         prbs_next;

   assign accept = tvalid_q & m_axis.tready;
   assign deq    = (state_q == ST_IDLE) && (pend_q != '0) && cfg_en;

   // Lowest enabled channel, and lowest enabled channel above the current one.
   always_comb begin
      first_found = 1'b0;
      first_ch    = '0;
      next_found  = 1'b0;
      next_ch     = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask_q[i]) begin
            first_found = 1'b1;
            first_ch    = CH_W'(i);
         end
         if (mask_q[i] && (i > int'(ch_q))) begin
            next_found = 1'b1;
            next_ch    = CH_W'(i);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      mode_d    = mode_q;
      mask_d    = mask_q;
      len_d     = len_q;
      blen_d    = blen_q;
      seed_d    = seed_q;
      ch_d      = ch_q;
      beat_d    = beat_q;
      burst_d   = burst_q;
      base_d    = base_q;
      tvalid_d  = tvalid_q;
      tlast_d   = tlast_q;
      tuser_d   = tuser_q;
      tdest_d   = tdest_q;
      start_rec = 1'b0;
      load_data = 1'b0;
      line_inc  = 1'b0;
      drop_inc  = 2'd0;
      rec_ch    = ch_q;

      // A trigger and a dequeue in the same cycle cancel out.
      if (trigger && !deq) begin
         if (pend_q == PEND_W'(TRIG_Q)) drop_inc = drop_inc + 2'd1;
         else                           pend_d   = pend_q + PEND_W'(1);
      end else if (!trigger && deq) begin
         pend_d = pend_q - PEND_W'(1);
      end

      case (state_q)
         ST_IDLE: if (deq) begin
            state_d = ST_LOAD;
            mode_d  = mode_e'(cfg_mode);
            mask_d  = cfg_ch_en;
            len_d   = (cfg_info_len  == '0) ? LEN_W'(1) : cfg_info_len;
            blen_d  = (cfg_burst_len == '0) ? LEN_W'(1) : cfg_burst_len;
            seed_d  = cfg_seed;
         end
         ST_LOAD: if (!first_found) begin
            drop_inc = drop_inc + 2'd1;
            state_d  = ST_IDLE;
         end else begin
            start_rec = 1'b1;
            rec_ch    = first_ch;
         end
         ST_GEN: if (accept) begin
            if (beat_q == len_q - LEN_W'(1)) begin
               tvalid_d = 1'b0;
               tlast_d  = 1'b0;
               tuser_d  = 1'b0;
               state_d  = ST_NEXT;
            end else begin
               beat_d    = beat_q + LEN_W'(1);
               burst_d   = tlast_q ? '0 : burst_q + LEN_W'(1);
               base_d    = tlast_q ? 16'h0 : base_q + 16'(LANES);
               tuser_d   = 1'b0;
               load_data = 1'b1;
            end
         end
         default: if (next_found) begin
            start_rec = 1'b1;
            rec_ch    = next_ch;
         end else begin
            line_inc = 1'b1;
            state_d  = ST_IDLE;
         end
      endcase

      if (start_rec) begin
         state_d   = ST_GEN;
         ch_d      = rec_ch;
         tdest_d   = rec_ch;
         beat_d    = '0;
         burst_d   = '0;
         base_d    = 16'h0;
         tvalid_d  = 1'b1;
         tuser_d   = 1'b1;
         load_data = 1'b1;
      end
      if (load_data)
         tlast_d = (burst_d == blen_q - LEN_W'(1)) || (beat_d == len_q - LEN_W'(1));
   end

   assign line_d   = line_q + {31'h0, line_inc};
   assign drop_sum = {1'b0, drop_q} + {31'h0, drop_inc};
   assign drop_d   = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
   assign busy_d   = (state_d != ST_IDLE);
   assign tdata_d  = load_data ? tdata_pat : tdata_q;

   info_pattern_gen_mc_prbs32 u_prbs (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (start_rec),
      .step      (accept),
      .seed      (seed_q),
      .prbs_next (prbs_next)
   );

   // Per-lane pattern for the beat about to be registered (uses the _d counters).
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam int DST = (REORDER != 0) ? int'(lane_reorder(gi, LANES)) : gi;
      logic [15:0] ramp_v, stamp_v, lane_v;

      assign ramp_v = base_d + 16'(gi);
      if (gi == 0) begin : g_s0
         assign stamp_v = line_q[15:0];
      end else if (gi == 1) begin : g_s1
         assign stamp_v = 16'(ch_d);
      end else if (gi == 2) begin : g_s2
         assign stamp_v = 16'(beat_d);
      end else begin : g_sr
         assign stamp_v = ramp_v;
      end

      always_comb begin
         case (mode_q)
            MODE_RAMP:  lane_v = ramp_v;
            MODE_CONST: lane_v = (gi % 2 == 1) ? seed_q[31:16] : seed_q[15:0];
            MODE_PRBS:  lane_v = (gi % 2 == 1) ? prbs_next[31:16] : prbs_next[15:0];
            default:    lane_v = stamp_v;
         endcase
      end

      assign tdata_pat[DST*LANE_W +: LANE_W] = lane_v;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         pend_q   <= '0;
         mode_q   <= MODE_RAMP;
         mask_q   <= '0;
         len_q    <= LEN_W'(1);
         blen_q   <= LEN_W'(1);
         seed_q   <= '0;
         ch_q     <= '0;
         beat_q   <= '0;
         burst_q  <= '0;
         base_q   <= '0;
         line_q   <= '0;
         drop_q   <= '0;
         busy_q   <= 1'b0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tuser_q  <= 1'b0;
         tdest_q  <= '0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         mode_q   <= mode_d;
         mask_q   <= mask_d;
         len_q    <= len_d;
         blen_q   <= blen_d;
         seed_q   <= seed_d;
         ch_q     <= ch_d;
         beat_q   <= beat_d;
         burst_q  <= burst_d;
         base_q   <= base_d;
         line_q   <= line_d;
         drop_q   <= drop_d;
         busy_q   <= busy_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         tuser_q  <= tuser_d;
         tdest_q  <= tdest_d;
      end
   end

   assign m_axis.tdata   = tdata_q;
   assign m_axis.tvalid  = tvalid_q;
   assign m_axis.tlast   = tlast_q;
   assign m_axis.tdest   = tdest_q;
   assign m_axis.tuser   = tuser_q;
   assign busy           = busy_q;
   assign line_cnt       = line_q;
   assign trig_drop_cnt  = drop_q;
endmodule
